// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter (package wb_arb_pkg).
package wb_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int TO_CNT_W = 16;

    // Index width for n requesters; never below 1 so a 2-master index still has a bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between the Wishbone masters, the arbiter and the shared slave interconnect.
interface wb_rr_arbiter_if #(
    parameter int NM = 2,
    parameter int DW = 32,
    parameter int AW = 8
);
    localparam int BE = DW / 8;

    logic [NM-1:0]    wbm_cyc_i;
    logic [NM-1:0]    wbm_stb_i;
    logic [NM-1:0]    wbm_we_i;
    logic [NM*BE-1:0] wbm_sel_i;
    logic [NM*AW-1:0] wbm_adr_i;
    logic [NM*DW-1:0] wbm_dat_i;
    logic [NM*DW-1:0] wbm_dat_o;
    logic [NM-1:0]    wbm_ack_o;
    logic [NM-1:0]    wbm_err_o;
    logic             wbs_cyc_o;
    logic             wbs_stb_o;
    logic             wbs_we_o;
    logic [BE-1:0]    wbs_sel_o;
    logic [AW-1:0]    wbs_adr_o;
    logic [DW-1:0]    wbs_dat_o;
    logic [DW-1:0]    wbs_dat_i;
    logic             wbs_ack_i;
    logic [NM-1:0]    grant_o;

    // Arbiter side: slave to the masters, master to the interconnect.
    modport slave (
        input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
        input  wbs_dat_i, wbs_ack_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o,
        output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
        output grant_o
    );

    // Environment side: the masters plus the slave device.
    modport master (
        output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
        output wbs_dat_i, wbs_ack_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o,
        input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
        input  grant_o
    );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester searched from last+1, wrapping.
module rr_pick #(
    parameter int NM = 2,
    parameter int IW = 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 1; off <= NM; off++) begin
            cand = IW'((int'(last) + off) % NM);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave bus between NUM_MASTERS masters.
// Define WB_ARB_TIMEOUT_EN to enable the stalled-strobe timeout that drives wbm_err_o.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_n_i,
    wb_rr_arbiter_if.slave bus
);

    localparam int NM = NUM_MASTERS;
    localparam int DW = BUS_DATA_WIDTH;
    localparam int AW = BUS_ADDR_WIDTH;
    localparam int BE = DW / 8;
    localparam int IW = clog2(NM);

    if (NM < 2 || NM > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("wb_rr_arbiter: parameter out of range");
    end

    arb_state_e    state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [IW-1:0] last_q, last_d;
    logic [NM-1:0] pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          to_hit;
    int            gi;

    rr_pick #(.NM(NM), .IW(IW)) u_pick (
        .req  (bus.wbm_cyc_i),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // Grant is captured only from IDLE, so every handover passes through one IDLE cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.wbm_cyc_i) begin
                    state_d = ST_BUSY;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                end
            end
            ST_BUSY: begin
                if (!bus.wbm_cyc_i[gidx_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NM - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = '0;
        to_hit   = 1'b0;
        if (state_q == ST_BUSY && bus.wbm_stb_i[gidx_q] && !bus.wbs_ack_i) begin
            if (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES)) to_hit = 1'b1;
            else                                       to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) to_cnt_q <= '0;
        else             to_cnt_q <= to_cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    // Everything is gated by BUSY, so reset forces all bus outputs low at once.
    always_comb begin
        gi            = int'(gidx_q);
        bus.wbs_cyc_o = 1'b0;
        bus.wbs_stb_o = 1'b0;
        bus.wbs_we_o  = 1'b0;
        bus.wbs_sel_o = '0;
        bus.wbs_adr_o = '0;
        bus.wbs_dat_o = '0;
        bus.wbm_dat_o = '0;
        bus.wbm_ack_o = '0;
        bus.wbm_err_o = '0;
        if (state_q == ST_BUSY) begin
            bus.wbs_cyc_o              = bus.wbm_cyc_i[gidx_q];
            bus.wbs_stb_o              = bus.wbm_stb_i[gidx_q] & ~to_hit;
            bus.wbs_we_o               = bus.wbm_we_i[gidx_q];
            bus.wbs_sel_o              = bus.wbm_sel_i[gi*BE +: BE];
            bus.wbs_adr_o              = bus.wbm_adr_i[gi*AW +: AW];
            bus.wbs_dat_o              = bus.wbm_dat_i[gi*DW +: DW];
            bus.wbm_ack_o[gidx_q]      = bus.wbs_ack_i;
            bus.wbm_dat_o[gi*DW +: DW] = bus.wbs_dat_i;
            bus.wbm_err_o[gidx_q]      = to_hit;
        end
    end

    assign bus.grant_o = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: per-cycle vector table plus reset and stall sequences.
module tb_wb_rr_arbiter;

    localparam int NM = 2;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.NM(NM), .DW(DW), .AW(AW)) bus ();

    wb_rr_arbiter #(
        .NUM_MASTERS    (NM),
        .BUS_DATA_WIDTH (DW),
        .BUS_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus.slave)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic [31:0] sdat;
        logic        sack;
        logic [1:0]  egnt;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input string name, input logic rst, input logic [1:0] cyc,
                                input logic [1:0] stb, input logic [31:0] sdat,
                                input logic sack, input logic [1:0] egnt);
        vec_t v;
        v.name = name; v.rst = rst; v.cyc = cyc; v.stb = stb;
        v.sdat = sdat; v.sack = sack; v.egnt = egnt;
        vq.push_back(v);
    endfunction

    function automatic logic [116:0] obs();
        return {bus.grant_o, bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_sel_o,
                bus.wbs_adr_o, bus.wbs_dat_o, bus.wbm_ack_o, bus.wbm_dat_o, bus.wbm_err_o};
    endfunction

    // m0: read, sel F, adr 00, dat A5A50000.  m1: write, sel 3, adr 04, dat 12345678.
    function automatic logic [116:0] expect_of(input vec_t v);
        logic        c, s, w;
        logic [3:0]  sel;
        logic [7:0]  adr;
        logic [31:0] d;
        logic [1:0]  ack;
        logic [63:0] mdat;
        c = 1'b0; s = 1'b0; w = 1'b0; sel = '0; adr = '0; d = '0; ack = '0; mdat = '0;
        if (!v.rst && v.egnt == 2'b01) begin
            c = v.cyc[0]; s = v.stb[0]; w = 1'b0; sel = 4'hF; adr = 8'h00; d = 32'hA5A50000;
            ack = {1'b0, v.sack}; mdat = {32'h0, v.sdat};
        end else if (!v.rst && v.egnt == 2'b10) begin
            c = v.cyc[1]; s = v.stb[1]; w = 1'b1; sel = 4'h3; adr = 8'h04; d = 32'h12345678;
            ack = {v.sack, 1'b0}; mdat = {v.sdat, 32'h0};
        end
        return {(v.rst ? 2'b00 : v.egnt), c, s, w, sel, adr, d, ack, mdat, 2'b00};
    endfunction

    task automatic check(input string name, input logic [116:0] got, input logic [116:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        bus.wbm_we_i  = 2'b10;
        bus.wbm_sel_i = {4'h3, 4'hF};
        bus.wbm_adr_i = {8'h04, 8'h00};
        bus.wbm_dat_i = {32'h12345678, 32'hA5A50000};
        bus.wbs_dat_i = '0;
        bus.wbs_ack_i = 1'b0;

        // single read by m0
        add("t1_idle",      0, 2'b00, 2'b00, 32'h0,        0, 2'b00);
        add("t1_req",       0, 2'b01, 2'b01, 32'hEEEEEEEE, 0, 2'b00);
        add("t1_ack",       0, 2'b01, 2'b01, 32'hEEEEEEEE, 1, 2'b01);
        add("t1_release",   0, 2'b00, 2'b00, 32'h0,        0, 2'b01);
        add("t1_back_idle", 0, 2'b00, 2'b00, 32'h0,        0, 2'b00);
        // simultaneous request right after reset
        add("t2_reset",     1, 2'b00, 2'b00, 32'h0,        0, 2'b00);
        add("t2_both_req",  0, 2'b11, 2'b11, 32'h0,        0, 2'b00);
        add("t2_m0_ack",    0, 2'b11, 2'b11, 32'h11110000, 1, 2'b01);
        add("t2_m0_drop",   0, 2'b10, 2'b10, 32'h0,        0, 2'b01);
        add("t2_gap",       0, 2'b10, 2'b10, 32'h0,        0, 2'b00);
        add("t2_m1_ack",    0, 2'b10, 2'b10, 32'h22220000, 1, 2'b10);
        add("t2_m1_drop",   0, 2'b00, 2'b00, 32'h0,        0, 2'b10);
        add("t2_idle",      0, 2'b00, 2'b00, 32'h0,        0, 2'b00);
        // both keep requesting: 01,10,01,10
        add("t3_req",       0, 2'b11, 2'b11, 32'h0,        0, 2'b00);
        add("t3_g1_ack",    0, 2'b11, 2'b11, 32'h00000001, 1, 2'b01);
        add("t3_g1_drop",   0, 2'b10, 2'b10, 32'h0,        0, 2'b01);
        add("t3_gap1",      0, 2'b11, 2'b11, 32'h0,        0, 2'b00);
        add("t3_g2_ack",    0, 2'b11, 2'b11, 32'h00000002, 1, 2'b10);
        add("t3_g2_drop",   0, 2'b01, 2'b01, 32'h0,        0, 2'b10);
        add("t3_gap2",      0, 2'b11, 2'b11, 32'h0,        0, 2'b00);
        add("t3_g3_ack",    0, 2'b11, 2'b11, 32'h00000003, 1, 2'b01);
        add("t3_g3_drop",   0, 2'b10, 2'b10, 32'h0,        0, 2'b01);
        add("t3_gap3",      0, 2'b11, 2'b11, 32'h0,        0, 2'b00);
        add("t3_g4_ack",    0, 2'b11, 2'b11, 32'h00000004, 1, 2'b10);
        add("t3_g4_drop",   0, 2'b00, 2'b00, 32'h0,        0, 2'b10);
        add("t3_idle",      0, 2'b00, 2'b00, 32'h0,        0, 2'b00);
        // m1 write arrives while m0 busy; release and request coincide
        add("t4_m0_req",    0, 2'b01, 2'b01, 32'h0,        0, 2'b00);
        add("t4_m1_waits",  0, 2'b11, 2'b11, 32'h0,        0, 2'b01);
        add("t4_m0_ack",    0, 2'b11, 2'b11, 32'h0000AAAA, 1, 2'b01);
        add("t4_m0_drop",   0, 2'b10, 2'b10, 32'h0,        0, 2'b01);
        add("t4_gap",       0, 2'b10, 2'b10, 32'h0,        0, 2'b00);
        add("t4_m1_write",  0, 2'b10, 2'b10, 32'h0,        1, 2'b10);
        add("t4_m1_drop",   0, 2'b00, 2'b00, 32'h0,        0, 2'b10);
        add("t4_idle",      0, 2'b00, 2'b00, 32'h0,        0, 2'b00);
        // m1 gives up before its grant arrives
        add("t5_m0_req",    0, 2'b01, 2'b01, 32'h0,        0, 2'b00);
        add("t5_m1_req",    0, 2'b11, 2'b11, 32'h0,        0, 2'b01);
        add("t5_m1_quit",   0, 2'b01, 2'b01, 32'h0000BBBB, 1, 2'b01);
        add("t5_m0_drop",   0, 2'b00, 2'b00, 32'h0,        0, 2'b01);
        add("t5_no_m1",     0, 2'b00, 2'b00, 32'h0,        0, 2'b00);
        add("t5_idle",      0, 2'b00, 2'b00, 32'h0,        0, 2'b00);

        repeat (2) tick();
        check("reset_outputs", obs(), '0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            tick();
            rst_n         = !vq[i].rst;
            bus.wbm_cyc_i = vq[i].cyc;
            bus.wbm_stb_i = vq[i].stb;
            bus.wbs_dat_i = vq[i].sdat;
            bus.wbs_ack_i = vq[i].sack;
            #1;
            check({vq[i].name, "_grant"}, {115'd0, bus.grant_o}, {115'd0, vq[i].egnt});
            check(vq[i].name, obs(), expect_of(vq[i]));
        end

        // async reset while m1 holds the bus
        tick();
        bus.wbm_cyc_i = 2'b10; bus.wbm_stb_i = 2'b10;
        bus.wbs_ack_i = 1'b0;  bus.wbs_dat_i = '0;
        tick();
        check("rst_pre_grant", {115'd0, bus.grant_o}, {115'd0, 2'b10});
        bus.wbs_ack_i = 1'b1; bus.wbs_dat_i = 32'hCCCCCCCC;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_zero", obs(), '0);
        tick();
        rst_n = 1'b1;
        bus.wbm_cyc_i = 2'b11; bus.wbm_stb_i = 2'b11;
        bus.wbs_ack_i = 1'b0;  bus.wbs_dat_i = '0;
        tick();
        #1;
        check("rst_after_m0_wins", {115'd0, bus.grant_o}, {115'd0, 2'b01});
        bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0;
        repeat (2) tick();

        // m0 strobes with no slave ack
        bus.wbm_cyc_i = 2'b01; bus.wbm_stb_i = 2'b01;
        tick();
        for (int k = 0; k < 12; k++) begin
            #1;
`ifdef WB_ARB_TIMEOUT_EN
            check($sformatf("stall_k%0d", k), {113'd0, bus.wbm_err_o, bus.wbs_stb_o, bus.wbs_cyc_o},
                  {113'd0, (k == 8) ? 2'b01 : 2'b00, (k == 8) ? 1'b0 : 1'b1, 1'b1});
`else
            check($sformatf("stall_k%0d", k), {113'd0, bus.wbm_err_o, bus.wbs_stb_o, bus.wbs_cyc_o},
                  {113'd0, 2'b00, 1'b1, 1'b1});
`endif
            tick();
        end
        bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
